// File: rtl/gamma_lut_stream_if.sv
// AXI4-Stream video beat bundle (pixel + start-of-frame + end-of-line) shared by
// the input and output sides of gamma_lut_stream.
interface gamma_lut_stream_if #(
   parameter int unsigned CH = 3,
   parameter int unsigned DW = 8
);
   logic             tvalid;
   logic             tready;
   logic [CH*DW-1:0] tdata;
   logic             tuser;
   logic             tlast;

   modport master (output tvalid, tdata, tuser, tlast, input tready);
   modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/gamma_lut_stream.sv
// Per-channel double-buffered gamma LUT on an AXI4-Stream pixel path. New tables
// arrive over the packet loader and swap in only at a start-of-frame pixel.
module gamma_lut_stream #(
   parameter int unsigned CH = 3,
   parameter int unsigned DW = 8,
   parameter int unsigned CW = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   gamma_lut_stream_if.slave  s_axis,
   gamma_lut_stream_if.master m_axis,
   input  logic               ld_sop,
   input  logic               ld_eop,
   input  logic               ld_vld,
   input  logic [CW-1:0]      ld_ch,
   input  logic [DW-1:0]      ld_data,
   output logic               ld_err,
   output logic [CH-1:0]      active_bank,
   output logic [CH-1:0]      tbl_valid
);
   localparam int unsigned DEPTH = 2 ** DW;

   typedef enum logic {IDLE, LOAD} ld_state_t;

   logic [DW-1:0]    mem [CH][2][DEPTH];
   ld_state_t        state;
   logic [CW-1:0]    ch_q;
   logic [DW:0]      addr;
   logic [CH-1:0]    pend;

   logic             en;
   logic             accept;
   logic [CH-1:0]    swap;
   logic [CH-1:0]    bank_rd;
   logic [CH-1:0]    tv_rd;

   logic             s1_valid;
   logic             s1_user;
   logic             s1_last;
   logic [CH*DW-1:0] s1_pix;
   logic [CH-1:0]    s1_tv;
   logic [DW-1:0]    rd_q [CH];

   logic             sop_bad;
   logic             beat_live;
   logic [CW-1:0]    beat_ch;
   logic [DW:0]      beat_addr;
   logic             wr_en;

   assign en            = !m_axis.tvalid || m_axis.tready;
   assign s_axis.tready = en;
   assign accept        = s_axis.tvalid && en;

   // A start-of-frame pixel already reads the freshly committed bank.
   assign swap    = (accept && s_axis.tuser) ? pend : '0;
   assign bank_rd = active_bank ^ swap;
   assign tv_rd   = tbl_valid | swap;

   always_comb begin
      sop_bad = (32'(ld_ch) >= CH);
      for (int unsigned c = 0; c < CH; c++) begin
         if (ld_ch == CW'(c) && pend[c]) sop_bad = 1'b1;
      end
   end

   assign beat_ch   = ld_sop ? ld_ch : ch_q;
   assign beat_addr = ld_sop ? '0 : addr;
   assign beat_live = ld_vld && (ld_sop ? !sop_bad : (state == LOAD));
   assign wr_en     = beat_live && !beat_addr[DW];

   always_ff @(posedge clk) begin
      if (wr_en) mem[beat_ch][~active_bank[beat_ch]][beat_addr[DW-1:0]] <= ld_data;
      if (en) begin
         for (int unsigned c = 0; c < CH; c++) begin
            rd_q[c] <= mem[c][bank_rd[c]][s_axis.tdata[c*DW +: DW]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid      <= 1'b0;
         s1_user       <= 1'b0;
         s1_last       <= 1'b0;
         s1_pix        <= '0;
         s1_tv         <= '0;
         m_axis.tvalid <= 1'b0;
         m_axis.tuser  <= 1'b0;
         m_axis.tlast  <= 1'b0;
         m_axis.tdata  <= '0;
      end else if (en) begin
         s1_valid      <= s_axis.tvalid;
         s1_user       <= s_axis.tuser;
         s1_last       <= s_axis.tlast;
         s1_pix        <= s_axis.tdata;
         s1_tv         <= tv_rd;
         m_axis.tvalid <= s1_valid;
         m_axis.tuser  <= s1_user;
         m_axis.tlast  <= s1_last;
         for (int unsigned c = 0; c < CH; c++) begin
            m_axis.tdata[c*DW +: DW] <= s1_tv[c] ? rd_q[c] : s1_pix[c*DW +: DW];
         end
      end
   end

   // Loader FSM; an SOP while loading restarts the packet on the (re-latched) channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ch_q        <= '0;
         addr        <= '0;
         pend        <= '0;
         active_bank <= '0;
         tbl_valid   <= '0;
         ld_err      <= 1'b0;
      end else begin
         ld_err      <= 1'b0;
         active_bank <= active_bank ^ swap;
         tbl_valid   <= tbl_valid | swap;
         pend        <= pend & ~swap;
         if (ld_vld && ld_sop && sop_bad) begin
            ld_err <= 1'b1;
            state  <= IDLE;
            addr   <= '0;
         end else if (beat_live) begin
            ch_q <= beat_ch;
            if (ld_eop) begin
               if (beat_addr == (DW+1)'(DEPTH - 1)) pend[beat_ch] <= 1'b1;
               else                                  ld_err        <= 1'b1;
               state <= IDLE;
               addr  <= '0;
            end else begin
               state <= LOAD;
               addr  <= beat_addr[DW] ? beat_addr : beat_addr + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_gamma_lut_stream.sv
// Randomized self-checking bench for gamma_lut_stream against a table/queue model
// of the loader, frame-start swap and 2-stage stream.
module tb_gamma_lut_stream;
   localparam int unsigned CH = 3;
   localparam int unsigned DW = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       ld_sop, ld_eop, ld_vld;
   logic [1:0] ld_ch;
   logic [7:0] ld_data;
   logic       ld_err;
   logic [2:0] active_bank;
   logic [2:0] tbl_valid;

   always #5 clk = ~clk;

   gamma_lut_stream_if #(.CH(CH), .DW(DW)) s_if ();
   gamma_lut_stream_if #(.CH(CH), .DW(DW)) m_if ();

   gamma_lut_stream #(.CH(CH), .DW(DW), .CW(2)) dut (
      .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
      .ld_sop(ld_sop), .ld_eop(ld_eop), .ld_vld(ld_vld), .ld_ch(ld_ch), .ld_data(ld_data),
      .ld_err(ld_err), .active_bank(active_bank), .tbl_valid(tbl_valid)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int err_pulses = 0;
   bit done;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: committed table per channel, pending table, packet beat queue.
   logic [7:0] cur_tbl [CH][256];
   logic [7:0] nxt_tbl [CH][256];
   bit [CH-1:0] m_pend, m_tv, m_bank;
   bit          in_pkt;
   int unsigned pkt_ch;
   logic [7:0]  beats [$];
   bit          exp_err;
   typedef struct packed { logic [23:0] d; logic u; logic l; } beat_t;
   beat_t outq [$];

   function automatic logic [23:0] gamma_ref(input logic [23:0] px);
      logic [23:0] r;
      logic [7:0]  x;
      for (int c = 0; c < CH; c++) begin
         x = px[c*8 +: 8];
         r[c*8 +: 8] = m_tv[c] ? cur_tbl[c][x] : x;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      bit [CH-1:0] pend_old;
      bit          err_n;
      beat_t       b;
      if (rst) begin
         m_pend = '0; m_tv = '0; m_bank = '0; in_pkt = 0; exp_err = 0;
         beats.delete(); outq.delete();
      end else begin
         chk("ld_err", ld_err, exp_err);
         if (ld_err) err_pulses++;
         chk("active_bank", active_bank, m_bank);
         chk("tbl_valid", tbl_valid, m_tv);
         chk("s_tready", s_if.tready, !m_if.tvalid || m_if.tready);
         if (m_if.tvalid) begin
            if (outq.size() == 0) chk("unexpected_out_valid", m_if.tvalid, 1'b0);
            else begin
               chk("out_data", m_if.tdata, outq[0].d);
               chk("out_user", m_if.tuser, outq[0].u);
               chk("out_last", m_if.tlast, outq[0].l);
               if (m_if.tready) void'(outq.pop_front());
            end
         end
         pend_old = m_pend;
         if (s_if.tvalid && s_if.tready) begin
            if (s_if.tuser) begin
               for (int c = 0; c < CH; c++) begin
                  if (m_pend[c]) begin
                     for (int i = 0; i < 256; i++) cur_tbl[c][i] = nxt_tbl[c][i];
                     m_tv[c] = 1; m_bank[c] = ~m_bank[c]; m_pend[c] = 0;
                  end
               end
            end
            b.d = gamma_ref(s_if.tdata); b.u = s_if.tuser; b.l = s_if.tlast;
            outq.push_back(b);
         end
         err_n = 0;
         if (ld_vld) begin
            if (ld_sop) begin
               if (ld_ch >= CH || pend_old[ld_ch]) begin err_n = 1; in_pkt = 0; end
               else begin in_pkt = 1; pkt_ch = ld_ch; beats.delete(); end
            end
            if (in_pkt) begin
               beats.push_back(ld_data);
               if (ld_eop) begin
                  if (beats.size() == 256) begin
                     for (int i = 0; i < 256; i++) nxt_tbl[pkt_ch][i] = beats[i];
                     m_pend[pkt_ch] = 1;
                  end else err_n = 1;
                  in_pkt = 0;
               end
            end
         end
         exp_err = err_n;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic put_pix(input logic [23:0] d, input bit u, input bit l);
      int k = 0;
      s_if.tvalid = 1; s_if.tdata = d; s_if.tuser = u; s_if.tlast = l;
      @(negedge clk);
      while (!s_if.tready && k < 200) begin @(negedge clk); k++; end
      if (k >= 200) chk("accept_timeout", s_if.tready, 1'b1);
      @(posedge clk); #1;
      s_if.tvalid = 0;
   endtask

   task automatic pipe_check(input string name, input logic [23:0] exp);
      @(negedge clk);
      chk({name, "_lat1_valid"}, m_if.tvalid, 1'b0);
      @(negedge clk);
      chk({name, "_lat2_valid"}, m_if.tvalid, 1'b1);
      chk({name, "_data"}, m_if.tdata, exp);
   endtask

   task automatic load_pkt(input int ch, input int n, input bit rnd, input bit holes, input bit sof_on_eop);
      for (int i = 0; i < n; i++) begin
         if (holes && $urandom_range(3) == 0) begin
            tick(); ld_vld = 0; ld_sop = 1'($urandom_range(1)); ld_eop = 0; ld_data = 8'($urandom);
         end
         tick();
         ld_vld = 1; ld_sop = (i == 0); ld_eop = (i == n - 1); ld_ch = 2'(ch);
         ld_data = rnd ? 8'($urandom) : 8'(255 - i);
         if (sof_on_eop && i == n - 1) begin
            s_if.tvalid = 1; s_if.tuser = 1; s_if.tlast = 0; s_if.tdata = 24'($urandom);
         end
      end
      tick();
      ld_vld = 0; ld_sop = 0; ld_eop = 0;
      if (sof_on_eop) s_if.tvalid = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      s_if.tvalid = 0; s_if.tdata = '0; s_if.tuser = 0; s_if.tlast = 0; m_if.tready = 1;
      ld_vld = 0; ld_sop = 0; ld_eop = 0; ld_ch = '0; ld_data = '0;
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_m_tvalid", m_if.tvalid, 1'b0);
      chk("rst_m_tdata", m_if.tdata, 24'h0);
      chk("rst_m_tuser", m_if.tuser, 1'b0);
      chk("rst_m_tlast", m_if.tlast, 1'b0);
      chk("rst_s_tready", s_if.tready, 1'b1);
      chk("rst_ld_err", ld_err, 1'b0);
      chk("rst_active_bank", active_bank, 3'b000);
      chk("rst_tbl_valid", tbl_valid, 3'b000);

      tick(); put_pix(24'h123456, 0, 0); pipe_check("identity_unloaded", 24'h123456);

      load_pkt(0, 256, 0, 0, 0);
      tick(); put_pix(24'h000010, 0, 0); pipe_check("identity_before_sof", 24'h000010);
      tick(); put_pix(24'h000010, 1, 0); pipe_check("inverse_ch0", 24'h0000EF);
      chk("inverse_tbl_valid", tbl_valid, 3'b001);
      chk("inverse_active_bank", active_bank, 3'b001);

      // Five-cycle downstream stall in the middle of a 10-pixel line.
      tick();
      fork
         for (int i = 0; i < 10; i++) put_pix(24'($urandom), i == 0, i == 9);
         begin
            repeat (3) @(posedge clk);
            #1 m_if.tready = 0;
            repeat (2) @(negedge clk);
            chk("stall_s_tready_low", s_if.tready, 1'b0);
            repeat (4) @(posedge clk);
            #1 m_if.tready = 1;
         end
      join
      repeat (6) tick();

      e0 = err_pulses; load_pkt(2, 200, 1, 0, 0); repeat (3) tick();
      chk("short_pkt_err", err_pulses - e0, 1);
      put_pix(24'($urandom), 1, 0); repeat (3) tick();
      chk("short_pkt_no_swap", tbl_valid[2], 1'b0);
      e0 = err_pulses; load_pkt(3, 4, 1, 0, 0); repeat (3) tick();
      chk("bad_ch_err", err_pulses - e0, 1);

      load_pkt(1, 256, 1, 1, 0);
      e0 = err_pulses; load_pkt(1, 3, 1, 0, 0); repeat (3) tick();
      chk("pend_reject_err", err_pulses - e0, 1);
      chk("pend_reject_tv", tbl_valid[1], 1'b0);
      put_pix(24'($urandom), 1, 0); repeat (3) tick();
      chk("ch1_swapped_tv", tbl_valid[1], 1'b1);
      e0 = err_pulses; load_pkt(1, 256, 1, 0, 0); repeat (3) tick();
      chk("ch1_reload_ok", err_pulses - e0, 0);
      put_pix(24'($urandom), 0, 0); put_pix(24'($urandom), 0, 1);
      put_pix(24'($urandom), 1, 0); repeat (3) tick();
      chk("ch1_reload_bank", active_bank[1], 1'b0);

      load_pkt(2, 256, 1, 0, 1); repeat (3) tick();
      chk("deferred_swap_tv", tbl_valid[2], 1'b0);
      put_pix(24'($urandom), 1, 0); repeat (3) tick();
      chk("deferred_swap_next_tv", tbl_valid[2], 1'b1);

      done = 0;
      fork
         begin
            for (int p = 0; p < 14; p++) begin
               int kind;
               kind = $urandom_range(9);
               repeat ($urandom_range(30, 1)) tick();
               if (kind < 6)       load_pkt($urandom_range(2), 256, 1, 1, 0);
               else if (kind == 6) load_pkt(3, $urandom_range(5, 1), 1, 0, 0);
               else if (kind == 7) load_pkt($urandom_range(2), $urandom_range(255, 1), 1, 1, 0);
               else if (kind == 8) load_pkt($urandom_range(2), $urandom_range(260, 257), 1, 0, 0);
               else begin
                  for (int i = 0; i < 4; i++) begin
                     tick(); ld_vld = 1; ld_sop = 0; ld_eop = (i == 3); ld_data = 8'($urandom);
                  end
                  tick(); ld_vld = 0; ld_eop = 0;
               end
            end
            done = 1;
         end
         begin
            while (!done) begin
               tick();
               s_if.tvalid = ($urandom_range(3) != 0);
               s_if.tdata  = 24'($urandom);
               s_if.tuser  = ($urandom_range(40) == 0);
               s_if.tlast  = ($urandom_range(7) == 0);
            end
            tick(); s_if.tvalid = 0;
         end
         begin
            while (!done) begin
               tick(); m_if.tready = ($urandom_range(3) != 0);
            end
            tick(); m_if.tready = 1;
         end
      join
      repeat (8) tick();
      chk("drain_outstanding", outq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/gamma_lut_stream.md
# gamma_lut_stream

Parametrised per-channel gamma look-up block for the AXI4-Stream video path, the next generation of the fixed 3×8-bit gamma stage. Each of CH channels owns a double-buffered 2^DW-entry table loaded from the I2C packet port. A newly loaded table takes effect only at a start of frame, so no frame ever mixes two curves. The block supports full AXI-Stream backpressure and sits between the input video stream and downstream colour processing.

## Interface
- CH, 3, number of colour channels packed in tdata (channel c at bits [c*DW +: DW])
- DW, 8, bits per channel; table depth 2^DW, table entry width DW
- CW, $clog2(CH) (min 1), width of ld_ch
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axis_tvalid / s_axis_tuser / s_axis_tlast  in  1  input stream; tuser = start of frame
- s_axis_tdata  in  CH*DW  input pixel
- s_axis_tready  out  1  input accept
- m_axis_tvalid / m_axis_tuser / m_axis_tlast  out  1  output stream
- m_axis_tdata  out  CH*DW  corrected pixel
- m_axis_tready  in  1  downstream accept
- ld_sop, ld_eop, ld_vld  in  1  load packet framing and beat strobe
- ld_ch  in  CW  target channel, sampled on the SOP beat
- ld_data  in  DW  table entry
- ld_err  out  1  one-cycle pulse on a rejected packet or beat
- active_bank  out  CH  current read bank per channel
- tbl_valid  out  CH  channel has a committed table in use

## Operation
- Storage: per channel, two banks of 2^DW × DW simple dual-port RAM. The write port is driven by the loader; the read port is addressed by the channel's input sample. Synchronous read, 1-cycle latency.
- Loader states: IDLE, LOAD.
  - IDLE + ld_vld&ld_sop: latch ld_ch, write ld_data to address 0 of bank ~active_bank[ch], set addr=1, go to LOAD.
  - LOAD + ld_vld: write at addr, addr++.
  - ld_sop in LOAD restarts the packet at address 0; the channel is re-latched.
  - Beats with ld_vld=0 are ignored.
  - ld_vld without SOP in IDLE: beat dropped, no error.
- EOP beat (written like any other beat): if exactly 2^DW beats were received, including the EOP beat, set pend[ch] and return to IDLE. Otherwise pulse ld_err, discard the packet (no commit) and return to IDLE.
- SOP with ld_ch ≥ CH, or with pend[ld_ch]=1 (swap still outstanding): packet rejected. Pulse ld_err, stay in IDLE, write nothing. The remaining beats of that packet are dropped silently.
- Swap: on an accepted input beat with s_axis_tuser=1, for every channel with pend=1:
  - toggle active_bank;
  - set tbl_valid=1;
  - clear pend.
  - That tuser pixel and all later pixels use the new bank.
- Commit and tuser accept in the same cycle: swap deferred to the next frame start.
- tbl_valid[c]=0: channel c output equals its input sample (identity), delayed to the same latency.
- The address counter is DW+1 bits so that a count of 2^DW is detectable. Excess beats (more than 2^DW before EOP) are not written, and the packet fails at EOP.

## Timing
- Pipeline: stage 1 is the RAM read with sideband registers, stage 2 is the output register. Latency is 2 cycles from input accept to m_axis_tvalid when unstalled.
- Global enable en = !m_axis_tvalid | m_axis_tready. s_axis_tready = en (combinational). While en=0, RAM read enable is low and all stage registers hold.
- Throughput: 1 pixel/clk while m_axis_tready=1.
- While stalled, m_axis_tdata, m_axis_tuser and m_axis_tlast are stable.
- tuser and tlast travel with their pixel exactly.
- The bank selected for a pixel is captured at its accept cycle. A swap never alters pixels already in flight.
- Reset values: m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0; stage valids 0; s_axis_tready=1; ld_err=0; active_bank=0; tbl_valid=0; pend=0; loader in IDLE with addr=0.
- Reset mid-load aborts the packet, and nothing is committed. RAM contents are not cleared and are don't-care until reloaded.
- ld_err is asserted in the cycle after the offending beat.

## Test plan
- Reset then stream without loading: pixel 0x123456 (CH=3, DW=8) -> m_axis_tdata=0x123456 two cycles later; tbl_valid=0.
- Load ch0 with inverse (entry i = 255−i), then send frame with tuser=1 on pixel 0x000010 -> output 0x0000EF; tbl_valid=001; active_bank[0]=1. Before that frame start, pixels are still identity.
- Hold m_axis_tready=0 for 5 cycles mid-frame -> s_axis_tready=0 one beat after the pipeline fills; output held stable; no pixel lost or duplicated; tlast position preserved.
- Packet with 200 beats ending in EOP -> ld_err pulse; no swap at next tuser. SOP with ld_ch=3 -> ld_err; nothing written.
- Commit ch1, then SOP for ch1 before any tuser -> ld_err; after the next tuser, reload ch1 is accepted and takes effect at the following frame.
- Commit on the same cycle as a tuser accept -> that frame uses the old table; the next tuser swaps.
